axis_negator_sat: RTL
=====================

// Module: axis_negator_sat
// PURPOSE
//   Multi-channel AXI4-Stream sign-control stage with a registered, full-throughput output.
//   Negates each packed channel under its own config bit, with optional saturation of the
//   most-negative input. Counts overflow beats for software monitoring.
//   Sits in DSP chains between the ADC/DDS/filter streams and mixers or DMA writers.
// PARAMETERS
//   CHANNEL_WIDTH  16  bits per channel, signed two's complement (>=2)
//   CHANNELS       2   number of channels packed LSB-first in tdata (>=1)
//   SATURATE       1   1: -(-2^(W-1)) -> 2^(W-1)-1; 0: wrap (result = -2^(W-1))
// PORTS
//   aclk           in   1          clock, all logic on rising edge
//   areset         in   1          synchronous reset, active-high
//   cfg_data       in   CHANNELS   bit i=1 negates channel i
//   s_axis_tready  out  1          input ready (registered)
//   s_axis_tdata   in   CHANNELS*CHANNEL_WIDTH  packed input samples
//   s_axis_tvalid  in   1          input valid
//   m_axis_tready  in   1          downstream ready
//   m_axis_tdata   out  CHANNELS*CHANNEL_WIDTH  packed output samples (registered)
//   m_axis_tvalid  out  1          output valid (registered)
//   sts_data       out  32         overflow beat count, saturating at 0xFFFFFFFF
// BEHAVIOUR
//   - Reset (areset=1 at a clock edge): m_axis_tvalid=0, m_axis_tdata=0, s_axis_tready=0
//     during reset, then 1 on the first cycle after; skid register empty; sts_data=0.
//     Reset mid-transfer discards all held beats; no beat is emitted after reset.
//   - Per channel i: x = s_axis_tdata[i*W +: W]; y = cfg_data[i] ? -x : x.
//     Compute -x at W+1 bits. If x == -2^(W-1) and cfg_data[i]=1, the channel overflows:
//     y = 2^(W-1)-1 when SATURATE=1, else y = x.
//   - cfg_data is sampled only on the accepted beat (s_axis_tvalid & s_axis_tready).
//     A change takes effect on the next accepted beat and never splits a beat.
//   - Pipeline: output register plus one-entry skid register.
//     Latency is 1 cycle from acceptance to m_axis_tvalid when the output is empty.
//     Throughput is 1 beat/cycle while m_axis_tready=1.
//   - Handshake: s_axis_tready = ~skid_valid, registered.
//     Accept while the output is full and m_axis_tready=0: the processed beat goes to skid,
//     and s_axis_tready drops on the next cycle.
//     Output transfer with skid full: skid moves to the output, and s_axis_tready rises on
//     the next cycle.
//     Accept and output transfer in the same cycle with skid empty: the new beat replaces
//     the output.
//     m_axis_tdata/m_axis_tvalid hold stable while m_axis_tvalid=1 and m_axis_tready=0.
//     No beat is lost, duplicated or reordered.
//   - sts_data: +1 per accepted beat in which >=1 channel overflowed (regardless of
//     SATURATE); holds at 0xFFFFFFFF. It updates the cycle after acceptance.
//   - Data width arithmetic is exact; no rounding; unused upper bits do not exist.
// TESTING (W=16, CHANNELS=2, SATURATE=1 unless noted)
//   1. cfg=2'b01, in {0x0005, 0x0003}; mtready=1 -> out {0x0005, 0xFFFD} one cycle later.
//   2. cfg=2'b11, in {0x8000, 0x8000} -> out {0x7FFF, 0x7FFF}, sts_data 0->1.
//      Same with SATURATE=0 -> out {0x8000, 0x8000}, sts_data=1.
//   3. Stream 100 ramp beats, cfg=2'b10, random m_axis_tready and s_axis_tvalid
//      -> 100 beats out, in order, ch1 negated and ch0 passed; no drop or duplicate.
//   4. Hold mtready=0 with 3 beats offered -> 2 beats held (output+skid).
//      s_axis_tready=0 from the next cycle; data stable; release -> all delivered.
//   5. Toggle cfg every cycle during a stream -> each output matches the cfg present at
//      that beat's acceptance.
//   6. Assert areset with skid full and sts_data=5 -> next cycle mtvalid=0, sts_data=0,
//      s_axis_tready=1 the cycle after release; no stale beat emitted.

Source files
------------

// File: rtl/axis_negator_sat.sv
// AXI4-Stream per-channel negation stage with optional saturation of the most-negative
// input, a registered output slot backed by a one-entry skid register, and an overflow counter.
module axis_negator_sat #(
    parameter int unsigned CHANNEL_WIDTH = 16,
    parameter int unsigned CHANNELS      = 2,
    parameter bit          SATURATE      = 1'b1
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic [CHANNELS-1:0]               cfg_data,
    output logic                              s_axis_tready,
    input  logic [CHANNELS*CHANNEL_WIDTH-1:0] s_axis_tdata,
    input  logic                              s_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [CHANNELS*CHANNEL_WIDTH-1:0] m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic [31:0]                       sts_data
);

    localparam int unsigned W  = CHANNEL_WIDTH;
    localparam int unsigned DW = CHANNELS * CHANNEL_WIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] MOST_POS = ~MOST_NEG;

    logic [DW-1:0]       proc_data;
    logic [CHANNELS-1:0] ovf;
    logic                ovf_any;
    logic                accept;

    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] skid_data_q, skid_data_d;
    logic          skid_valid_q, skid_valid_d;
    logic          ready_q;
    logic [31:0]   sts_q, sts_d;

    assign accept        = s_axis_tvalid & ready_q;
    assign ovf_any       = |ovf;
    assign s_axis_tready = ready_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign sts_data      = sts_q;

    // Negation is done at W+1 bits so -(-2^(W-1)) is representable before it is clipped.
    always_comb begin
        logic [W-1:0] x;
        logic [W:0]   neg;
        proc_data = '0;
        ovf       = '0;
        x         = '0;
        neg       = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            x   = s_axis_tdata[i*W +: W];
            neg = (W+1)'(0) - {x[W-1], x};
            if (cfg_data[i] && (x == MOST_NEG)) begin
                ovf[i] = 1'b1;
                proc_data[i*W +: W] = SATURATE ? MOST_POS : x;
            end else if (cfg_data[i]) begin
                proc_data[i*W +: W] = neg[W-1:0];
            end else begin
                proc_data[i*W +: W] = x;
            end
        end
    end

    // Input ready is ~skid_valid, so an accept never coincides with a full skid.
    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        sts_d        = sts_q;
        if (!out_valid_q || m_axis_tready) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_data_d  = proc_data;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_data_d  = proc_data;
            skid_valid_d = 1'b1;
        end
        if (accept && ovf_any && (sts_q != '1)) begin
            sts_d = sts_q + 32'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            sts_q        <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
            sts_q        <= sts_d;
        end
    end

endmodule
